// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for an asynchronous FIFO.
// Synchronises the Gray write pointer and registers empty, almost-empty, count and underflow.
module fifo_rd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_INC,
  input  logic [FIFO_DEPTH-1:0] W_PTR_G,
  output logic                  R_EMPTY,
  output logic                  R_ALMOST_EMPTY,
  output logic [FIFO_DEPTH-1:0] R_COUNT,
  output logic                  R_UNDERFLOW,
  output logic [FIFO_DEPTH-2:0] R_ADDR,
  output logic [FIFO_DEPTH-1:0] R_PTR
);

  localparam logic [FIFO_DEPTH-1:0] AeLevel = FIFO_DEPTH'(AE_LEVEL);

  logic [FIFO_DEPTH-1:0] rbin_q, rbin_d;
  logic [FIFO_DEPTH-1:0] rq1_q, rq2_q;
  logic [FIFO_DEPTH-1:0] r_ptr_q, r_ptr_d;
  logic [FIFO_DEPTH-2:0] r_addr_q, r_addr_d;
  logic [FIFO_DEPTH-1:0] r_count_q, r_count_d;
  logic                  r_empty_q, r_empty_d;
  logic                  r_almost_empty_q, r_almost_empty_d;
  logic                  r_underflow_q, r_underflow_d;
  logic                  rd_en;
  logic [FIFO_DEPTH-1:0] wbin;

  function automatic logic [FIFO_DEPTH-1:0] gray2bin(input logic [FIFO_DEPTH-1:0] g);
    logic [FIFO_DEPTH-1:0] b;
    b[FIFO_DEPTH-1] = g[FIFO_DEPTH-1];
    for (int i = FIFO_DEPTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    rd_en            = R_INC & ~r_empty_q;
    rbin_d           = rbin_q + {{(FIFO_DEPTH-1){1'b0}}, rd_en};
    r_ptr_d          = rbin_d ^ (rbin_d >> 1);
    r_addr_d         = rbin_d[FIFO_DEPTH-2:0];
    wbin             = gray2bin(rq2_q);
    // Flags use the post-pop pointer so a pop is visible with no extra lag.
    r_count_d        = wbin - rbin_d;
    r_empty_d        = (r_ptr_d == rq2_q);
    r_almost_empty_d = (r_count_d <= AeLevel);
    r_underflow_d    = R_INC & r_empty_q;
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rbin_q           <= '0;
      rq1_q            <= '0;
      rq2_q            <= '0;
      r_ptr_q          <= '0;
      r_addr_q         <= '0;
      r_count_q        <= '0;
      r_empty_q        <= 1'b1;
      r_almost_empty_q <= 1'b1;
      r_underflow_q    <= 1'b0;
    end else begin
      rbin_q           <= rbin_d;
      rq1_q            <= W_PTR_G;
      rq2_q            <= rq1_q;
      r_ptr_q          <= r_ptr_d;
      r_addr_q         <= r_addr_d;
      r_count_q        <= r_count_d;
      r_empty_q        <= r_empty_d;
      r_almost_empty_q <= r_almost_empty_d;
      r_underflow_q    <= r_underflow_d;
    end
  end

  assign R_EMPTY        = r_empty_q;
  assign R_ALMOST_EMPTY = r_almost_empty_q;
  assign R_COUNT        = r_count_q;
  assign R_UNDERFLOW    = r_underflow_q;
  assign R_ADDR         = r_addr_q;
  assign R_PTR          = r_ptr_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus random traffic
// compared against a pointer-count model with a two-edge write-pointer delay.
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_inc;
  logic [3:0] w_ptr_g;
  logic       r_empty, r_almost_empty, r_underflow;
  logic [3:0] r_count, r_ptr;
  logic [2:0] r_addr;

  fifo_rd_ctrl #(.FIFO_DEPTH(4), .AE_LEVEL(1)) dut (
    .R_CLK          (r_clk),
    .R_RST          (r_rst),
    .R_INC          (r_inc),
    .W_PTR_G        (w_ptr_g),
    .R_EMPTY        (r_empty),
    .R_ALMOST_EMPTY (r_almost_empty),
    .R_COUNT        (r_count),
    .R_UNDERFLOW    (r_underflow),
    .R_ADDR         (r_addr),
    .R_PTR          (r_ptr)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: rp = total pops, w = total writes, whist = write totals seen at the two prior edges.
  int rp = 0;
  int w  = 0;
  int whist[$];
  int m_cnt = 0;
  bit m_empty = 1'b1;
  bit m_uf = 1'b0;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = 4'(b % 16);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("empty", 32'(r_empty), 32'(m_empty));
    chk("almost_empty", 32'(r_almost_empty), 32'(m_cnt <= 1));
    chk("count", 32'(r_count), 32'(m_cnt));
    chk("underflow", 32'(r_underflow), 32'(m_uf));
    chk("addr", 32'(r_addr), 32'(rp % 8));
    chk("ptr", 32'(r_ptr), 32'(gray(rp)));
  endtask

  // One clock with reset low; model advances using pre-edge state.
  task automatic step(input bit inc);
    int seen;
    r_rst   = 1'b0;
    r_inc   = inc;
    w_ptr_g = gray(w);
    @(posedge r_clk);
    m_uf = inc && m_empty;
    if (inc && !m_empty) rp++;
    seen = whist.pop_front();
    whist.push_back(w);
    m_cnt   = seen - rp;
    m_empty = (m_cnt == 0);
    #1;
    check_model();
  endtask

  task automatic do_reset(input bit inc, input logic [3:0] wg);
    r_rst   = 1'b1;
    r_inc   = inc;
    w_ptr_g = wg;
    @(posedge r_clk);
    rp = 0; w = 0; m_cnt = 0; m_empty = 1'b1; m_uf = 1'b0;
    whist = '{0, 0};
    #1;
    check_model();
  endtask

  int addr_wraps;
  bit ptr_wrap_seen;
  logic [2:0] prev_addr;
  logic [3:0] prev_ptr;

  initial begin
    r_rst = 1'b1; r_inc = 1'b0; w_ptr_g = '0;
    whist = '{0, 0};

    // 1: reset held two cycles with pop request and nonzero write pointer
    do_reset(1'b1, 4'b0101);
    do_reset(1'b1, 4'b0101);
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_ptr", 32'(r_ptr), 32'd0);

    // 2: three entries arrive; empty falls after the third edge
    w = 3;
    step(1'b0); step(1'b0);
    chk("lat_still_empty", 32'(r_empty), 32'd1);
    step(1'b0);
    chk("lat_count3", 32'(r_count), 32'd3);
    chk("lat_not_ae", 32'(r_almost_empty), 32'd0);
    step(1'b1); chk("pop1_addr", 32'(r_addr), 32'd1);
    step(1'b1); chk("pop2_ae", 32'(r_almost_empty), 32'd1);
    step(1'b1); chk("pop3_ptr", 32'(r_ptr), 32'b0010);
    chk("pop3_empty", 32'(r_empty), 32'd1);

    // 3: underflow for two cycles
    step(1'b1); chk("uf1", 32'(r_underflow), 32'd1);
    step(1'b1); chk("uf2", 32'(r_underflow), 32'd1);
    chk("uf_addr", 32'(r_addr), 32'd3);
    step(1'b0); chk("uf_clear", 32'(r_underflow), 32'd0);

    // 4: stream 20 entries through the wrap, filling to full depth first
    for (int i = 0; i < 8; i++) begin w++; step(1'b0); end
    step(1'b0); step(1'b0);
    chk("full_count", 32'(r_count), 32'd8);
    addr_wraps = 0; ptr_wrap_seen = 1'b0;
    for (int i = 0; i < 200 && rp < 23; i++) begin
      prev_addr = r_addr; prev_ptr = r_ptr;
      if (w < 23 && (w - rp) < 8) w++;
      step(1'b1);
      if (prev_addr == 3'd7 && r_addr == 3'd0) addr_wraps++;
      if (prev_ptr == 4'b1000 && r_ptr == 4'b0000) ptr_wrap_seen = 1'b1;
      if (r_count > 4'd8) chk("count_le8", 32'(r_count), 32'd8);
    end
    chk("stream_done", 32'(rp), 32'd23);
    chk("addr_wraps", 32'(addr_wraps), 32'd2);
    chk("ptr_wrap", 32'(ptr_wrap_seen), 32'd1);
    chk("stream_empty", 32'(r_empty), 32'd1);

    // 5: full depth from reset, then pop coinciding with a new write arriving
    do_reset(1'b0, 4'b0000);
    w = 8;
    step(1'b0); step(1'b0); step(1'b0);
    chk("depth8_count", 32'(r_count), 32'd8);
    chk("depth8_empty", 32'(r_empty), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("one_left", 32'(r_count), 32'd1);
    w = 9;
    step(1'b0); step(1'b0); step(1'b1);
    chk("net_count", 32'(r_count), 32'd1);
    chk("net_empty", 32'(r_empty), 32'd0);

    // 6: reset mid-stream with count 5
    for (int i = 0; i < 4; i++) begin w++; step(1'b0); end
    step(1'b0); step(1'b0);
    chk("pre_rst_count", 32'(r_count), 32'd5);
    do_reset(1'b1, 4'b0000);
    chk("mid_rst_count", 32'(r_count), 32'd0);
    step(1'b0);
    chk("post_rst_empty", 32'(r_empty), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && (w - rp) < 8) w++;
      step(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
